// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined chunked ripple-carry adder/subtractor with valid/ready streams
//
// Purpose:
//   Adds a + b + cin, or computes a - b as a + ~b + 1. The operands are cut into
//   STAGES chunks of WIDTH/STAGES bits. Stage k adds chunk k and registers the
//   carry for stage k+1. The operands and the partial sum travel down the pipe
//   with the carry, so a new operation can enter on every cycle. WIDTH must be a
//   multiple of STAGES.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operation offered on a, b, cin, sub
//   in_ready   operation accepted this cycle (global advance)
//   a, b       operands, WIDTH bits
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid on sum, cout, ovf
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (1 = no borrow when subtracting)
//   ovf        signed overflow
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Per-stage registers. b_q holds the operand already inverted for subtraction.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0]            c_q, v_q;
  logic                         ovf_q;

  // Inputs seen by each stage: the block ports for stage 0, the previous stage otherwise.
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_nxt;
  logic [STAGES-1:0]            c_src, c_nxt, v_src;
  logic [CW:0]                  chunk;
  logic                         ovf_nxt;
  logic                         adv;

  always_comb begin
    a_src   = '0;
    b_src   = '0;
    s_src   = '0;
    c_src   = '0;
    v_src   = '0;
    s_nxt   = '0;
    c_nxt   = '0;
    chunk   = '0;
    ovf_nxt = 1'b0;

    a_src[0] = a;
    b_src[0] = sub ? ~b : b;
    c_src[0] = sub | cin;
    v_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
            + {{CW{1'b0}}, c_src[k]};
      s_nxt[k]              = s_src[k];
      s_nxt[k][k*CW +: CW]  = chunk[CW-1:0];
      c_nxt[k]              = chunk[CW];
    end

    // Carry into MSB xor carry out equals "operand signs agree, result sign differs".
    ovf_nxt = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
              (s_nxt[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
  end

  assign adv = !v_q[STAGES-1] || out_ready;

  // Data registers load only for valid slots, so bubbles leave the last result on sum/cout/ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q <= v_src;
      for (int k = 0; k < STAGES; k++) begin
        if (v_src[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= c_nxt[k];
        end
      end
      if (v_src[STAGES-1]) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  // The last stage's operand copies feed nothing downstream.
  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed self-checking bench for adder_pipe
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit, 2-stage instance
  logic       iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  // default 16-bit, 4-stage instance
  logic        iv, ir, ov, orr, cin16, sub16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  adder_pipe #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  adder_pipe u16 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov), .out_ready(orr), .sum(sum16),
    .cout(cout16), .ovf(ovf16)
  );

  localparam int S16 = 4;

  localparam logic [7:0] A8   [6] = '{8'hFF, 8'h7F, 8'h05, 8'h10, 8'h80, 8'h80};
  localparam logic [7:0] B8   [6] = '{8'h01, 8'h01, 8'h07, 8'h20, 8'h80, 8'h01};
  localparam bit         C8   [6] = '{0, 0, 0, 1, 1, 0};
  localparam bit         SB8  [6] = '{0, 0, 1, 0, 1, 1};
  localparam logic [7:0] SUM8 [6] = '{8'h00, 8'h80, 8'hFE, 8'h31, 8'h00, 8'h7F};
  localparam bit         CO8  [6] = '{1, 0, 0, 0, 1, 1};
  localparam bit         OV8  [6] = '{0, 1, 0, 0, 0, 1};

  localparam logic [15:0] TA   [10] = '{16'hFFFF, 16'h1234, 16'h7FFF, 16'h8000, 16'h0000,
                                        16'hABCD, 16'h0FFF, 16'h8000, 16'h00F0, 16'hFFFF};
  localparam logic [15:0] TB   [10] = '{16'h0000, 16'h4321, 16'h0001, 16'h8000, 16'h0001,
                                        16'hABCD, 16'h0001, 16'h0001, 16'h0F10, 16'hFFFF};
  localparam bit          TC   [10] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 1};
  localparam bit          TS   [10] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
  localparam logic [15:0] TSUM [10] = '{16'h0000, 16'h5555, 16'h8000, 16'h0000, 16'hFFFF,
                                        16'h0000, 16'h1001, 16'h7FFF, 16'h1000, 16'hFFFF};
  localparam bit          TCO  [10] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 1};
  localparam bit          TOV  [10] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 0};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: full rate, out_ready=1; mode 1: out_ready=0 for 9 cycles then 1;
  // mode 2: random in_valid/out_ready at 50%.
  task automatic run_stream(input string name, input int n, input int mode);
    int in_idx  = 0;
    int out_idx = 0;
    int cyc     = 0;
    int acc[$];
    bit took;
    iv = 1'b0;
    while ((in_idx < n || out_idx < n) && cyc < 4000) begin
      if (in_idx < n) begin
        a16   = TA[in_idx % 10];
        b16   = TB[in_idx % 10];
        cin16 = TC[in_idx % 10];
        sub16 = TS[in_idx % 10];
      end
      if (mode == 2) begin
        if (!iv && in_idx < n) iv = 1'($urandom_range(0, 1));
        orr = 1'($urandom_range(0, 1));
      end else begin
        iv  = (in_idx < n);
        orr = (mode == 1) ? (cyc >= 9) : 1'b1;
      end
      #1;
      if (mode == 1 && cyc >= 4 && cyc < 9) begin
        check($sformatf("%s stall in_ready c%0d", name, cyc), 32'(ir), 32'(0));
        check($sformatf("%s stall out_valid c%0d", name, cyc), 32'(ov), 32'(1));
      end
      if (ov) begin
        if (out_idx < n) begin
          check($sformatf("%s sum #%0d", name, out_idx), 32'(sum16), 32'(TSUM[out_idx % 10]));
          check($sformatf("%s cout #%0d", name, out_idx), 32'(cout16), 32'(TCO[out_idx % 10]));
          check($sformatf("%s ovf #%0d", name, out_idx), 32'(ovf16), 32'(TOV[out_idx % 10]));
          if (orr) begin
            if (mode == 0)
              check($sformatf("%s latency #%0d", name, out_idx), 32'(cyc - acc[out_idx]), 32'(S16));
            out_idx++;
          end
        end else begin
          check($sformatf("%s extra result", name), 32'(ov), 32'(0));
        end
      end
      took = iv && ir;
      if (took) begin
        acc.push_back(cyc);
        in_idx++;
      end
      @(posedge clk);
      #1;
      if (took && mode == 2) iv = 1'b0;
      cyc++;
    end
    iv = 1'b0;
    check($sformatf("%s count in", name), 32'(in_idx), 32'(n));
    check($sformatf("%s count out", name), 32'(out_idx), 32'(n));
    orr = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("%s drained", name), 32'(ov), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    iv = 0; orr = 1; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst u8 out_valid", 32'(ov8), 32'(0));
    check("rst u8 sum", 32'(sum8), 32'(0));
    check("rst u8 cout", 32'(cout8), 32'(0));
    check("rst u8 ovf", 32'(ovf8), 32'(0));
    check("rst u8 in_ready", 32'(ir8), 32'(1));
    check("rst u16 out_valid", 32'(ov), 32'(0));
    check("rst u16 sum", 32'(sum16), 32'(0));
    check("rst u16 in_ready", 32'(ir), 32'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 8-bit, 2 stages: back-to-back directed ops, result 2 cycles after acceptance
    for (int t = 0; t < 7; t++) begin
      if (t < 6) begin
        iv8 = 1; a8 = A8[t]; b8 = B8[t]; cin8 = C8[t]; sub8 = SB8[t];
      end else begin
        iv8 = 0;
      end
      @(posedge clk);
      #1;
      if (t == 0) begin
        check("u8 not early", 32'(ov8), 32'(0));
      end else begin
        check($sformatf("u8 valid #%0d", t-1), 32'(ov8), 32'(1));
        check($sformatf("u8 sum #%0d", t-1), 32'(sum8), 32'(SUM8[t-1]));
        check($sformatf("u8 cout #%0d", t-1), 32'(cout8), 32'(CO8[t-1]));
        check($sformatf("u8 ovf #%0d", t-1), 32'(ovf8), 32'(OV8[t-1]));
      end
    end
    @(posedge clk);
    #1;
    check("u8 idle out_valid", 32'(ov8), 32'(0));
    check("u8 idle sum held", 32'(sum8), 32'(8'h7F));

    // 16-bit, 4 stages
    run_stream("full", 20, 0);
    run_stream("stall", 8, 1);
    run_stream("rand", 200, 2);

    // reset with three ops in flight
    orr = 1'b1;
    for (int t = 0; t < 3; t++) begin
      iv = 1; a16 = TA[t]; b16 = TB[t]; cin16 = TC[t]; sub16 = TS[t];
      @(posedge clk);
      #1;
    end
    iv  = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(ov), 32'(0));
    check("midrst sum", 32'(sum16), 32'(0));
    check("midrst in_ready", 32'(ir), 32'(1));
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      check($sformatf("postrst no stale c%0d", t), 32'(ov), 32'(0));
    end
    iv = 1; a16 = TA[1]; b16 = TB[1]; cin16 = TC[1]; sub16 = TS[1];
    @(posedge clk);
    #1;
    iv = 0;
    for (int t = 1; t < S16; t++) begin
      check($sformatf("postrst latency c%0d", t), 32'(ov), 32'(0));
      @(posedge clk);
      #1;
    end
    check("postrst valid", 32'(ov), 32'(1));
    check("postrst sum", 32'(sum16), 32'(16'h5555));
    check("postrst cout", 32'(cout16), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
